// File: rtl/alu_arb_pkg.sv
// Shared definitions for alu_arb: FSM state encoding, control-field bit
// positions, ALU op codes (matching the companion alu) and a saturating counter helper.
package alu_arb_pkg;

    localparam int NREQ  = 2;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bit positions inside each requester's 4-bit {Cin, invA, invB, sign} field.
    localparam int CTL_CIN  = 3;
    localparam int CTL_INVA = 2;
    localparam int CTL_INVB = 1;
    localparam int CTL_SIGN = 0;

    localparam logic [2:0] OP_RLL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_arb_if.sv
// Bundle of requester, response and ALU-side signals around alu_arb.
// slave = the arbiter; master = requesters, response sink and the ALU itself.
interface alu_arb_if
    import alu_arb_pkg::*;
#(
    parameter int W = 16
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_a;
    logic [NREQ*W-1:0]     req_b;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ*4-1:0]     req_ctl;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_id;
    logic [W-1:0]          resp_out;
    logic                  resp_ofl;
    logic                  resp_cout;
    logic                  resp_z;

    logic [W-1:0]          alu_a;
    logic [W-1:0]          alu_b;
    logic [2:0]            alu_op;
    logic                  alu_cin;
    logic                  alu_inva;
    logic                  alu_invb;
    logic                  alu_sign;
    logic [W-1:0]          alu_out;
    logic                  alu_ofl;
    logic                  alu_cout;
    logic                  alu_z;

    logic [NREQ*CNT_W-1:0] grant_cnt;

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_ctl,
        output req_ready,
        output resp_valid, resp_id, resp_out, resp_ofl, resp_cout, resp_z,
        input  resp_ready,
        output alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign,
        input  alu_out, alu_ofl, alu_cout, alu_z,
        output grant_cnt
    );

    modport master (
        output req_valid, req_a, req_b, req_op, req_ctl,
        input  req_ready,
        input  resp_valid, resp_id, resp_out, resp_ofl, resp_cout, resp_z,
        output resp_ready,
        input  alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign,
        output alu_out, alu_ofl, alu_cout, alu_z,
        input  grant_cnt
    );

endinterface

// File: rtl/alu_arb_rr.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// a tie goes to the requester that was not granted last.
module alu_arb_rr (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        gnt_valid_o = |req_valid_i;
        case (req_valid_i)
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_grant_i;
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Shares one combinational ALU between two requesters: round-robin grant, registered
// operands, one-cycle execute, tagged response. `define ALU_ARB_STATS_EN adds grant counters.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int W = 16
) (
    input  logic     clk,
    input  logic     rst,
    alu_arb_if.slave bus
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [3:0]   ctl;
    } cmd_t;

    state_e       state_q;
    logic         last_grant_q;
    cmd_t         cmd_q;
    cmd_t         cmd_d;
    logic         resp_valid_q;
    logic         resp_id_q;
    logic [W-1:0] resp_out_q;
    logic         resp_ofl_q;
    logic         resp_cout_q;
    logic         resp_z_q;

    logic         gnt_valid;
    logic         gnt_id;
    logic         handshake;

    alu_arb_rr u_rr (
        .req_valid_i  (bus.req_valid),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    // The winner's ready is offered only in IDLE and never while reset is asserted.
    assign handshake     = rst && (state_q == ST_IDLE) && gnt_valid;
    assign bus.req_ready = handshake ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        cmd_d.a   = gnt_id ? bus.req_a[W +: W]   : bus.req_a[0 +: W];
        cmd_d.b   = gnt_id ? bus.req_b[W +: W]   : bus.req_b[0 +: W];
        cmd_d.op  = gnt_id ? bus.req_op[3 +: 3]  : bus.req_op[0 +: 3];
        cmd_d.ctl = gnt_id ? bus.req_ctl[4 +: 4] : bus.req_ctl[0 +: 4];
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cmd_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_out_q   <= '0;
            resp_ofl_q   <= 1'b0;
            resp_cout_q  <= 1'b0;
            resp_z_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        cmd_q        <= cmd_d;
                        resp_id_q    <= gnt_id;
                        last_grant_q <= gnt_id;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_out_q   <= bus.alu_out;
                    resp_ofl_q   <= bus.alu_ofl;
                    resp_cout_q  <= bus.alu_cout;
                    resp_z_q     <= bus.alu_z;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.alu_a    = cmd_q.a;
    assign bus.alu_b    = cmd_q.b;
    assign bus.alu_op   = cmd_q.op;
    assign bus.alu_cin  = cmd_q.ctl[CTL_CIN];
    assign bus.alu_inva = cmd_q.ctl[CTL_INVA];
    assign bus.alu_invb = cmd_q.ctl[CTL_INVB];
    assign bus.alu_sign = cmd_q.ctl[CTL_SIGN];

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_out   = resp_out_q;
    assign bus.resp_ofl   = resp_ofl_q;
    assign bus.resp_cout  = resp_cout_q;
    assign bus.resp_z     = resp_z_q;

`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][CNT_W-1:0] cnt_q;
    logic [NREQ-1:0][CNT_W-1:0] cnt_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (handshake && (gnt_id == 1'(i))) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.grant_cnt = cnt_q;
`else
    assign bus.grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: behavioural ALU beside the DUT, directed scenarios
// and a randomized run checked against a transaction-level model of the arbiter.
module tb_alu_arb;
    import alu_arb_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] out;
        logic         ofl;
        logic         cout;
        logic         z;
    } res_t;

    typedef struct {
        logic id;
        res_t res;
        int   valid_at;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    res_t alu_now;

    alu_arb_if #(.W(W)) bus ();

    alu_arb #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: ctl = {Cin, invA, invB, sign}.
    function automatic res_t alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [2:0] op, input logic [3:0] ctl);
        logic [W-1:0]   ia;
        logic [W-1:0]   ib;
        logic [W:0]     sum;
        logic [2*W-1:0] rot;
        res_t           r;
        ia  = ctl[2] ? ~a : a;
        ib  = ctl[1] ? ~b : b;
        sum = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ctl[3]};
        rot = {ia, ia} << ib[3:0];
        r   = '0;
        case (op)
            3'b000: r.out = rot[2*W-1:W];
            3'b001: r.out = ia << ib[3:0];
            3'b010: r.out = W'($signed(ia) >>> ib[3:0]);
            3'b011: r.out = ia >> ib[3:0];
            3'b100: begin
                r.out  = sum[W-1:0];
                r.cout = sum[W];
                r.ofl  = ctl[0] ? ((ia[W-1] == ib[W-1]) && (sum[W-1] != ia[W-1])) : sum[W];
            end
            3'b101: r.out = ia & ib;
            3'b110: r.out = ia | ib;
            default: r.out = ia ^ ib;
        endcase
        r.z = (r.out == '0);
        return r;
    endfunction

    assign alu_now = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op,
                             {bus.alu_cin, bus.alu_inva, bus.alu_invb, bus.alu_sign});
    assign bus.alu_out  = alu_now.out;
    assign bus.alu_ofl  = alu_now.ofl;
    assign bus.alu_cout = alu_now.cout;
    assign bus.alu_z    = alu_now.z;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_lanes();
        bus.req_a   = 32'($urandom);
        bus.req_b   = 32'($urandom);
        bus.req_op  = 6'($urandom);
        bus.req_ctl = 8'($urandom);
    endtask

    task automatic set_lane(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op, input logic [3:0] ctl);
        bus.req_a[id*W +: W]  = a;
        bus.req_b[id*W +: W]  = b;
        bus.req_op[id*3 +: 3] = op;
        bus.req_ctl[id*4 +: 4] = ctl;
    endtask

    function automatic res_t lane_ref(input int id);
        return alu_ref(bus.req_a[id*W +: W], bus.req_b[id*W +: W],
                       bus.req_op[id*3 +: 3], bus.req_ctl[id*4 +: 4]);
    endfunction

    function automatic logic [W+W+3+4-1:0] lane_cmd(input int id);
        return {bus.req_a[id*W +: W], bus.req_b[id*W +: W],
                bus.req_op[id*3 +: 3], bus.req_ctl[id*4 +: 4]};
    endfunction

    // Full operation on one requester with an always-ready sink; starts and ends in IDLE.
    task automatic issue(input int id);
        rand_lanes();
        bus.req_valid  = (id == 0) ? 2'b01 : 2'b10;
        bus.resp_ready = 1'b1;
        step();
        bus.req_valid = 2'b00;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid  = 2'b11;
        bus.resp_ready = 1'b1;
        rand_lanes();
        repeat (2) step();
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", bus.req_ready);
        end
        checks++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_ofl, bus.resp_cout, bus.resp_z} !== '0) begin
            errors++;
            $display("FAIL reset_resp: valid=%b id=%b out=%h flags=%b%b%b want all 0", bus.resp_valid,
                     bus.resp_id, bus.resp_out, bus.resp_ofl, bus.resp_cout, bus.resp_z);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin, bus.alu_inva, bus.alu_invb, bus.alu_sign} !== '0) begin
            errors++;
            $display("FAIL reset_alu: a=%h b=%h op=%b want 0", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        checks++;
        if (bus.grant_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %h want 0", bus.grant_cnt);
        end
        bus.req_valid = 2'b00;
        rst = 1'b1;
        step();
    endtask

    task automatic test_contention();
        res_t e;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rand_lanes();
            bus.req_valid = 2'b11;
            #1;
            e = lane_ref(k % 2);
            checks++;
            if (bus.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b want one-hot %0d", k, bus.req_ready, k % 2);
            end
            step();
            rand_lanes();
            #1;
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
                errors++;
                $display("FAIL contention_exec[%0d]: resp_valid=%b ready=%b want 0/00", k, bus.resp_valid, bus.req_ready);
            end
            step();
            #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'(k % 2) || bus.resp_out !== e.out) begin
                errors++;
                $display("FAIL contention_resp[%0d]: valid=%b id=%b out=%h want 1/%0d/%h", k,
                         bus.resp_valid, bus.resp_id, bus.resp_out, k % 2, e.out);
            end
            step();
        end
        bus.req_valid = 2'b00;
        step();
    endtask

    task automatic test_single();
        rand_lanes();
        set_lane(0, 16'h0005, 16'h0003, OP_ADD, 4'b0000);
        bus.req_valid  = 2'b01;
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b want 01", bus.req_ready);
        end
        step();
        bus.req_valid = 2'b11;
        rand_lanes();
        #1;
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin, bus.alu_inva, bus.alu_invb, bus.alu_sign} !==
            {16'h0005, 16'h0003, OP_ADD, 4'b0000}) begin
            errors++;
            $display("FAIL single_alu_in: a=%h b=%h op=%b want 0005/0003/100", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_exec_ready: got %b want 00", bus.req_ready);
        end
        step();
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_out !== 16'h0008 || bus.resp_z !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: valid=%b id=%b out=%h z=%b want 1/0/0008/0", bus.resp_valid,
                     bus.resp_id, bus.resp_out, bus.resp_z);
        end
        bus.req_valid = 2'b00;
        step();
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_resp_clear: got %b want 0", bus.resp_valid);
        end
        step();
    endtask

    task automatic test_flags();
        rand_lanes();
        set_lane(1, 16'h7FFF, 16'h0001, OP_ADD, 4'b0001);
        bus.req_valid  = 2'b10;
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL flags_ready: got %b want 10", bus.req_ready);
        end
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_out !== 16'h8000 || bus.resp_ofl !== 1'b1) begin
            errors++;
            $display("FAIL flags_ofl: valid=%b id=%b out=%h ofl=%b want 1/1/8000/1", bus.resp_valid,
                     bus.resp_id, bus.resp_out, bus.resp_ofl);
        end
        step();
        set_lane(1, 16'h0001, 16'h0001, OP_ADD, 4'b1010);
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        checks++;
        if (bus.resp_z !== 1'b1 || bus.resp_out !== 16'h0000 || bus.resp_cout !== 1'b1) begin
            errors++;
            $display("FAIL flags_zero: z=%b out=%h cout=%b want 1/0000/1", bus.resp_z, bus.resp_out, bus.resp_cout);
        end
        step();
    endtask

    task automatic test_backpressure();
        res_t e0;
        res_t e1;
        rand_lanes();
        bus.req_valid  = 2'b01;
        bus.resp_ready = 1'b0;
        #1;
        e0 = lane_ref(0);
        step();
        bus.req_valid = 2'b10;
        rand_lanes();
        step();
        for (int i = 0; i < 5; i++) begin
            rand_lanes();
            #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 ||
                {bus.resp_out, bus.resp_ofl, bus.resp_cout, bus.resp_z} !== e0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b id=%b out=%h want 1/0/%h", i, bus.resp_valid,
                         bus.resp_id, bus.resp_out, e0.out);
            end
            checks++;
            if (bus.req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want 00", i, bus.req_ready);
            end
            step();
        end
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_same_cycle: got %b want 00", bus.req_ready);
        end
        step();
        rand_lanes();
        #1;
        e1 = lane_ref(1);
        checks++;
        if (bus.req_ready !== 2'b10 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_regrant: ready=%b resp_valid=%b want 10/0", bus.req_ready, bus.resp_valid);
        end
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_out !== e1.out) begin
            errors++;
            $display("FAIL bp_r1_resp: valid=%b id=%b out=%h want 1/1/%h", bus.resp_valid, bus.resp_id,
                     bus.resp_out, e1.out);
        end
        step();
    endtask

    task automatic test_async_reset();
        res_t e;
        rand_lanes();
        bus.req_valid  = 2'b01;
        bus.resp_ready = 1'b1;
        step();
        bus.req_valid = 2'b11;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL areset_outputs: resp_valid=%b ready=%b want 0/00", bus.resp_valid, bus.req_ready);
        end
        checks++;
        if (bus.alu_a !== '0 || bus.alu_b !== '0) begin
            errors++;
            $display("FAIL areset_alu: a=%h b=%h want 0", bus.alu_a, bus.alu_b);
        end
        step();
        step();
        rst = 1'b1;
        rand_lanes();
        #1;
        e = lane_ref(0);
        checks++;
        if (bus.req_ready !== 2'b01 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_tie: ready=%b resp_valid=%b want 01/0", bus.req_ready, bus.resp_valid);
        end
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_out !== e.out) begin
            errors++;
            $display("FAIL areset_resp: valid=%b id=%b out=%h want 1/0/%h", bus.resp_valid, bus.resp_id,
                     bus.resp_out, e.out);
        end
        step();
    endtask

    task automatic test_random();
        exp_t                 q[$];
        logic                 m_last;
        bit                   m_free;
        bit                   exp_v;
        int                   win;
        int                   exec_at;
        logic [1:0]           v;
        logic [1:0]           exp_ready;
        logic [W+W+3+4-1:0]   exec_cmd;
        rst = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        rst      = 1'b1;
        m_last   = 1'b1;
        m_free   = 1'b1;
        exec_at  = -1;
        exec_cmd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = 2'($urandom_range(0, 3));
            rand_lanes();
            bus.req_valid  = v;
            bus.resp_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = 2'b00;
            win       = -1;
            if (m_free && v != 2'b00) begin
                if (v == 2'b11) win = m_last ? 0 : 1;
                else            win = (v == 2'b10) ? 1 : 0;
                exp_ready[win] = 1'b1;
            end
            checks++;
            if (bus.req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready @%0d: got %b want %b", cyc, bus.req_ready, exp_ready);
            end
            if (cyc == exec_at) begin
                checks++;
                if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin, bus.alu_inva, bus.alu_invb, bus.alu_sign} !== exec_cmd) begin
                    errors++;
                    $display("FAIL rand_alu_in @%0d: a=%h b=%h want a=%h b=%h", cyc, bus.alu_a, bus.alu_b,
                             exec_cmd[W+W+7-1 -: W], exec_cmd[W+7-1 -: W]);
                end
            end
            exp_v = (q.size() > 0) && (cyc >= q[0].valid_at);
            checks++;
            if (bus.resp_valid !== exp_v) begin
                errors++;
                $display("FAIL rand_resp_valid @%0d: got %b want %b", cyc, bus.resp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({bus.resp_id, bus.resp_out, bus.resp_ofl, bus.resp_cout, bus.resp_z} !== {q[0].id, q[0].res}) begin
                    errors++;
                    $display("FAIL rand_resp @%0d: id=%b out=%h flags=%b%b%b want id=%b out=%h flags=%b%b%b", cyc,
                             bus.resp_id, bus.resp_out, bus.resp_ofl, bus.resp_cout, bus.resp_z,
                             q[0].id, q[0].res.out, q[0].res.ofl, q[0].res.cout, q[0].res.z);
                end
                if (bus.resp_ready) begin
                    void'(q.pop_front());
                    m_free = 1'b1;
                end
            end
            if (win >= 0) begin
                q.push_back('{id: win[0], res: lane_ref(win), valid_at: cyc + 2});
                m_free   = 1'b0;
                m_last   = win[0];
                exec_at  = cyc + 1;
                exec_cmd = lane_cmd(win);
            end
            step();
        end
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_stats();
        logic [NREQ*CNT_W-1:0] exp_cnt;
        rst = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.grant_cnt !== '0) begin
            errors++;
            $display("FAIL stats_reset: got %h want 0", bus.grant_cnt);
        end
        issue(0);
        issue(1);
        issue(0);
        issue(1);
        issue(0);
`ifdef ALU_ARB_STATS_EN
        exp_cnt = {16'd2, 16'd3};
`else
        exp_cnt = '0;
`endif
        #1;
        checks++;
        if (bus.grant_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL stats_count: got %h want %h", bus.grant_cnt, exp_cnt);
        end
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.req_ctl    = '0;
        test_reset();
        test_contention();
        test_single();
        test_flags();
        test_backpressure();
        test_async_reset();
        test_random();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Shares one combinational 16-bit `alu` between two requesters (e.g. execute stage and address-gen/debug port).
- Arbitrates between them round-robin and registers the winning operands into the ALU.
- Captures the ALU result flags and returns them on a single response channel tagged with the requester ID.
- Sits beside the `alu` instance; drives all ALU inputs and samples all ALU outputs.

Parameters:
- W, 16, ALU data width; must match `alu`.
- NREQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; a handshake occurs when valid and ready are both high.
- req_a  in  2*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  2*W  operand B, same packing.
- req_op  in  2*3  ALU Op per requester.
- req_ctl  in  2*4  {Cin, invA, invB, sign} per requester.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  1  index of the requester the response belongs to.
- resp_out  out  W  captured ALU Out.
- resp_ofl  out  1  captured Ofl.
- resp_cout  out  1  captured Cout.
- resp_z  out  1  captured Z.
- alu_a, alu_b  out  W  ALU operands (registered).
- alu_op  out  3  ALU Op (registered).
- alu_cin, alu_inva, alu_invb, alu_sign  out  1 each  ALU controls (registered).
- alu_out  in  W  ALU result.
- alu_ofl, alu_cout, alu_z  in  1 each  ALU flags.
- grant_cnt  out  2*16  per-requester grant counters (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - State IDLE, last_grant=1, so requester 0 wins the first tie.
  - All ALU-side outputs 0; resp_* all 0; req_ready=0; grant_cnt=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready[g]=1 only for the arbitration winner g; the other bit is 0.
  - Winner selection:
    - if only one valid, that requester wins;
    - if both valid, the requester != last_grant wins.
  - On handshake:
    - latch that requester's a/b/op/ctl into the ALU-side registers;
    - latch g into resp_id and set last_grant=g;
    - go to EXEC.
  - With no valid, stay in IDLE; ALU-side registers hold their values.
- EXEC (exactly 1 cycle):
  - req_ready=0.
  - Sample alu_out/ofl/cout/z into the resp_* registers at the cycle end.
  - Set resp_valid=1 and go to RESP.
- RESP:
  - req_ready=0.
  - resp_* held stable while resp_valid=1 and resp_ready=0.
  - When resp_ready=1: clear resp_valid the next cycle and go to IDLE.
  - A new grant cannot occur in the same cycle as the response handshake.
- Latency: request handshake in cycle N, resp_valid high from cycle N+2. Minimum issue interval is 3 cycles per operation.
- req_ready is Mealy on req_valid in IDLE only; no combinational path from resp_ready to req_ready.
- Requester data is sampled only on its handshake cycle; changes at any other time are ignored.
- Reset mid-operation aborts immediately: the response is lost and the FSM returns to IDLE.
- No fairness starvation: under continuous contention, grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: grant_cnt[i*16 +: 16] increments on each handshake of requester i and saturates at 16'hFFFF; reset to 0.
- Not defined: grant_cnt is tied to 0 and no counter flops are synthesized.
- Port list is identical in both builds.

Decomposition:
- Shared package/include `alu_arb_pkg`:
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - CTL field indices CTL_CIN=3, CTL_INVA=2, CTL_INVB=1, CTL_SIGN=0;
  - ALU Op constants shared with `alu`.
- One sub-module `alu_arb_rr`: purely combinational 2-way round-robin picker.
  - Inputs: req_valid[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id.
- The FSM, operand/response registers and counters stay in `alu_arb`.

Test Plan:
- Single request: r0 valid with A=16'h0005, B=16'h0003, op=ADD, ctl=0. Expect req_ready[0]=1 in cycle 0, alu_a=5/alu_b=3 in cycle 1, and in cycle 2 resp_valid=1, resp_id=0, resp_out=16'h0008, Z=0.
- Contention after reset: both valid continuously, resp_ready=1. Expect grant order 0,1,0,1 and resp_id sequence 0,1,0,1 with one response every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid rises, with req_valid[1]=1 throughout. Expect resp_* stable, req_ready=2'b00, and r1 granted only the cycle after resp_ready returns to 1 and the FSM reaches IDLE.
- Flags: r1 issues A=16'h7FFF, B=16'h0001, ADD, sign=1 -> resp_out=16'h8000, resp_ofl=1. Then A=16'h0001, B=16'h0001, SUB-equivalent (invB=1, Cin=1) -> resp_z=1.
- Async reset in EXEC: assert rst=0 mid-cycle. Expect resp_valid=0 and req_ready=0 immediately. After release, r0 wins a tie.
- With ALU_ARB_STATS_EN defined: issue 3 grants to r0 and 2 to r1 -> grant_cnt = {16'd2, 16'd3}. Without the macro -> grant_cnt = 0.
